// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared types and constants for the unified memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int c_ADDR_W = 16;
    localparam int c_DATA_W = 16;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/mem_lat_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_lat_timer
// Description : Loadable down-counter timing the memory read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lat_timer #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int c_CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [c_CNT_W-1:0] c_LOAD_VAL = c_CNT_W'(MEM_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_LOAD_VAL;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - c_ONE;
        end
    end

    // Flags the last wait cycle, so the next cycle is the data-valid cycle.
    assign done = (r_count == c_ONE);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency memory between fetch and data ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 8) begin : g_badMemLat
            $error("mem_port_arbiter: MEM_LAT must lie in 1..8");
        end
    endgenerate

    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1) + 1;
    localparam logic [c_STARVE_W-1:0] c_STARVE_TOP = c_STARVE_W'(STARVE_MAX);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);
    localparam bit c_LAT_ONE = (MEM_LAT == 1);

    arbState_t           r_state;
    logic                r_owner;
    logic                r_ownWe;
    logic [c_STARVE_W-1:0] r_starveCnt;
    logic                r_ifAck;
    logic                r_dAck;
    logic [DATA_W-1:0]   r_ifRdata;
    logic [DATA_W-1:0]   r_dRdata;
    logic                r_memEn;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_memWdata;

    logic w_ifReqEff;
    logic w_dReqEff;
    logic w_forceIf;
    logic w_grantD;
    logic w_grantIf;
    logic w_timerDone;

    // A requester only advances its address after seeing its ack.
    assign w_ifReqEff = if_req & ~r_ifAck;
    assign w_dReqEff  = d_req  & ~r_dAck;
    assign w_forceIf  = w_ifReqEff && (r_starveCnt == c_STARVE_TOP);
    assign w_grantD   = (r_state == IDLE) && w_dReqEff && !w_forceIf;
    assign w_grantIf  = (r_state == IDLE) && w_ifReqEff && !w_grantD;

    mem_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_latTimer (
        .clk   (clk),
        .reset (reset),
        .load  (r_state == ISSUE),
        .dec   (r_state == WAIT),
        .done  (w_timerDone)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_ownWe     <= 1'b0;
            r_starveCnt <= '0;
            r_ifAck     <= 1'b0;
            r_dAck      <= 1'b0;
            r_ifRdata   <= '0;
            r_dRdata    <= '0;
            r_memEn     <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
        end else begin
            r_ifAck    <= 1'b0;
            r_dAck     <= 1'b0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            case (r_state)
                IDLE: begin
                    if (!if_req || w_grantIf) begin
                        r_starveCnt <= '0;
                    end else if (w_grantD && (r_starveCnt != c_STARVE_TOP)) begin
                        r_starveCnt <= r_starveCnt + c_STARVE_ONE;
                    end
                    if (w_grantD) begin
                        r_owner    <= OWN_D;
                        r_ownWe    <= d_we;
                        r_memEn    <= 1'b1;
                        r_memWe    <= d_we;
                        r_memAddr  <= d_addr;
                        r_memWdata <= d_wdata;
                        r_state    <= ISSUE;
                    end else if (w_grantIf) begin
                        r_owner    <= OWN_IF;
                        r_ownWe    <= 1'b0;
                        r_memEn    <= 1'b1;
                        r_memAddr  <= if_addr;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_state <= c_LAT_ONE ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (w_timerDone) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // mem_rdata is valid in this cycle; writes leave d_rdata alone.
                    if (r_owner == OWN_IF) begin
                        r_ifRdata <= mem_rdata;
                        r_ifAck   <= 1'b1;
                    end else begin
                        if (!r_ownWe) begin
                            r_dRdata <= mem_rdata;
                        end
                        r_dAck <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = r_ifRdata;
    assign if_ack    = r_ifAck;
    assign d_rdata   = r_dRdata;
    assign d_ack     = r_dAck;
    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign stall_if  = if_req & ~r_ifAck;
    assign stall_mem = d_req & ~r_dAck;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized self-checking bench for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] memArr [0:65535];
    logic [DATA_W-1:0] respData [int];

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: writes land on the strobe, reads return MEM_LAT later.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) memArr[mem_addr] = mem_wdata;
            else        respData[cyc + MEM_LAT] = memArr[mem_addr];
        end
    end

    always @(posedge clk) begin
        #2;
        if (respData.exists(cyc)) begin
            mem_rdata = respData[cyc];
            respData.delete(cyc);
        end else begin
            mem_rdata = 16'($urandom);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, if_ack, d_ack, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, if_ack, d_ack, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_membus: got %h expected 0", {mem_addr, mem_wdata});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        checks++;
        if ({stall_if, stall_mem} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 00", {stall_if, stall_mem});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_fetch();
        memArr[16'h0010] = 16'hABCD;
        for (int k = 0; k <= 5; k++) begin
            nextCycle();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0010; end
            if (k == 5) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_en !== (k == 1)) begin
                errors++; $display("FAIL fetch_mem_en c%0d: got %b expected %b", k, mem_en, (k == 1));
            end
            checks++;
            if (mem_addr !== ((k == 1) ? 16'h0010 : 16'h0000)) begin
                errors++; $display("FAIL fetch_mem_addr c%0d: got %h", k, mem_addr);
            end
            checks++;
            if (if_ack !== (k == 4)) begin
                errors++; $display("FAIL fetch_ack c%0d: got %b expected %b", k, if_ack, (k == 4));
            end
            checks++;
            if (stall_if !== (k <= 3)) begin
                errors++; $display("FAIL fetch_stall c%0d: got %b expected %b", k, stall_if, (k <= 3));
            end
            checks++;
            if (busy !== (k >= 1 && k <= 3)) begin
                errors++; $display("FAIL fetch_busy c%0d: got %b", k, busy);
            end
            if (k == 4) begin
                checks++;
                if (if_rdata !== 16'hABCD) begin
                    errors++; $display("FAIL fetch_rdata: got %h expected abcd", if_rdata);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] expAddr;
        memArr[16'h0020] = 16'h5A21;
        memArr[16'h0100] = 16'hC3D4;
        for (int k = 0; k <= 9; k++) begin
            nextCycle();
            if (k == 0) begin
                if_req = 1'b1; if_addr = 16'h0020;
                d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; d_wdata = 16'h0000;
            end
            if (k == 5) d_req = 1'b0;
            if (k == 9) if_req = 1'b0;
            @(negedge clk);
            expAddr = (k == 1) ? 16'h0100 : ((k == 5) ? 16'h0020 : 16'h0000);
            checks++;
            if (mem_en !== (k == 1 || k == 5) || mem_addr !== expAddr) begin
                errors++; $display("FAIL simul_issue c%0d: got en=%b addr=%h expected addr=%h", k, mem_en, mem_addr, expAddr);
            end
            checks++;
            if (d_ack !== (k == 4) || if_ack !== (k == 8)) begin
                errors++; $display("FAIL simul_acks c%0d: got d=%b if=%b", k, d_ack, if_ack);
            end
            checks++;
            if (stall_mem !== (k <= 3) || stall_if !== (k <= 7)) begin
                errors++; $display("FAIL simul_stalls c%0d: got mem=%b if=%b", k, stall_mem, stall_if);
            end
            if (k == 4) begin
                checks++;
                if (d_rdata !== 16'hC3D4) begin
                    errors++; $display("FAIL simul_d_rdata: got %h expected c3d4", d_rdata);
                end
            end
            if (k == 8) begin
                checks++;
                if (if_rdata !== 16'h5A21) begin
                    errors++; $display("FAIL simul_if_rdata: got %h expected 5a21", if_rdata);
                end
            end
        end
    endtask

    task automatic test_write();
        for (int k = 0; k <= 5; k++) begin
            nextCycle();
            if (k == 0) begin d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; end
            if (k == 5) begin d_req = 1'b0; d_we = 1'b0; d_wdata = 16'h0000; end
            @(negedge clk);
            checks++;
            if (mem_en !== (k == 1) || mem_we !== (k == 1)) begin
                errors++; $display("FAIL write_strobe c%0d: got en=%b we=%b", k, mem_en, mem_we);
            end
            checks++;
            if (mem_wdata !== ((k == 1) ? 16'h1234 : 16'h0000) || mem_addr !== ((k == 1) ? 16'h0200 : 16'h0000)) begin
                errors++; $display("FAIL write_bus c%0d: got addr=%h wdata=%h", k, mem_addr, mem_wdata);
            end
            checks++;
            if (d_ack !== (k == 4)) begin
                errors++; $display("FAIL write_ack c%0d: got %b expected %b", k, d_ack, (k == 4));
            end
            if (k >= 4) begin
                checks++;
                if (d_rdata !== 16'hC3D4) begin
                    errors++; $display("FAIL write_keeps_rdata c%0d: got %h expected c3d4", k, d_rdata);
                end
            end
        end
    endtask

    task automatic test_reset_wait();
        memArr[16'h0030] = 16'h7777;
        memArr[16'h0040] = 16'h4242;
        for (int k = 0; k <= 2; k++) begin
            nextCycle();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0030; end
            @(negedge clk);
            checks++;
            if (busy !== (k >= 1)) begin
                errors++; $display("FAIL rstwait_busy c%0d: got %b expected %b", k, busy, (k >= 1));
            end
        end
        #1;
        reset = 1'b1;
        if_req = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, if_ack, d_ack, busy} !== 5'b0) begin
            errors++; $display("FAIL rstwait_ctrl: got %b expected 00000", {mem_en, mem_we, if_ack, d_ack, busy});
        end
        checks++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL rstwait_data: got %h expected 0", {if_rdata, d_rdata, mem_addr, mem_wdata});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (if_ack !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rstwait_no_ack c%0d: got ack=%b en=%b busy=%b", k, if_ack, mem_en, busy);
            end
        end
        for (int k = 0; k <= 5; k++) begin
            nextCycle();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0040; end
            if (k == 5) if_req = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_en !== (k == 1) || mem_addr !== ((k == 1) ? 16'h0040 : 16'h0000)) begin
                errors++; $display("FAIL rstwait_reissue c%0d: got en=%b addr=%h", k, mem_en, mem_addr);
            end
            checks++;
            if (if_ack !== (k == 4)) begin
                errors++; $display("FAIL rstwait_ack c%0d: got %b expected %b", k, if_ack, (k == 4));
            end
            if (k == 4) begin
                checks++;
                if (if_rdata !== 16'h4242) begin
                    errors++; $display("FAIL rstwait_rdata: got %h expected 4242", if_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expAddr;
        memArr[16'h0050] = 16'h1357;
        memArr[16'h0060] = 16'h2468;
        for (int k = 0; k <= 10; k++) begin
            nextCycle();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0050; end
            if (k == 5) if_addr = 16'h0060;
            if (k == 10) if_req = 1'b0;
            @(negedge clk);
            expAddr = (k == 1) ? 16'h0050 : ((k == 6) ? 16'h0060 : 16'h0000);
            checks++;
            if (mem_en !== (k == 1 || k == 6) || mem_addr !== expAddr) begin
                errors++; $display("FAIL b2b_issue c%0d: got en=%b addr=%h expected addr=%h", k, mem_en, mem_addr, expAddr);
            end
            checks++;
            if (if_ack !== (k == 4 || k == 9)) begin
                errors++; $display("FAIL b2b_ack c%0d: got %b", k, if_ack);
            end
            if (k == 4 || k == 9) begin
                checks++;
                if (if_rdata !== ((k == 4) ? 16'h1357 : 16'h2468)) begin
                    errors++; $display("FAIL b2b_rdata c%0d: got %h", k, if_rdata);
                end
            end
        end
    endtask

    // Transaction-level model: each granted access owns the memory from the
    // cycle after the grant until its ack cycle, which is idle again.
    task automatic test_random();
        int          mIssue = -100;
        int          mAck = -100;
        logic        mOwnD = 1'b0;
        logic        mWe = 1'b0;
        logic [15:0] mAddr = '0;
        logic [15:0] mWdata = '0;
        logic [15:0] mData = '0;
        logic [15:0] expIf = '0;
        logic [15:0] expD = '0;
        int          starve = 0;
        logic        ifAckSeen = 1'b0;
        logic        dAckSeen = 1'b0;
        logic        idle, expAckIf, expAckD, expEn;
        logic        ifEff, dEff, grantD, grantIf;
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            nextCycle();
            if (if_req) begin
                if (ifAckSeen) begin
                    if ($urandom_range(0, 1) == 1) if_addr = 16'($urandom);
                    else if_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 40) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (d_req) begin
                if (dAckSeen) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d_addr = 16'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
                    end else d_req = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 40) begin
                d_req = 1'b1; d_addr = 16'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
            end
            @(negedge clk);
            idle     = (k >= mAck);
            expAckIf = (k == mAck) && !mOwnD;
            expAckD  = (k == mAck) && mOwnD;
            expEn    = (k == mIssue);
            if (expAckIf) expIf = mData;
            if (expAckD && !mWe) expD = mData;
            checks++;
            if (mem_en !== expEn) begin
                errors++; $display("FAIL rnd_mem_en c%0d: got %b expected %b", k, mem_en, expEn);
            end
            checks++;
            if (mem_addr !== (expEn ? mAddr : 16'h0) || mem_we !== (expEn && mWe)
                || mem_wdata !== ((expEn && mOwnD) ? mWdata : 16'h0)) begin
                errors++; $display("FAIL rnd_mem_bus c%0d: got addr=%h we=%b wdata=%h expected addr=%h we=%b",
                                   k, mem_addr, mem_we, mem_wdata, (expEn ? mAddr : 16'h0), (expEn && mWe));
            end
            checks++;
            if (if_ack !== expAckIf || d_ack !== expAckD) begin
                errors++; $display("FAIL rnd_acks c%0d: got if=%b d=%b expected if=%b d=%b", k, if_ack, d_ack, expAckIf, expAckD);
            end
            checks++;
            if (if_rdata !== expIf) begin
                errors++; $display("FAIL rnd_if_rdata c%0d: got %h expected %h", k, if_rdata, expIf);
            end
            checks++;
            if (d_rdata !== expD) begin
                errors++; $display("FAIL rnd_d_rdata c%0d: got %h expected %h", k, d_rdata, expD);
            end
            checks++;
            if (stall_if !== (if_req && !expAckIf) || stall_mem !== (d_req && !expAckD)) begin
                errors++; $display("FAIL rnd_stalls c%0d: got if=%b mem=%b", k, stall_if, stall_mem);
            end
            checks++;
            if (busy !== !idle) begin
                errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", k, busy, !idle);
            end
            ifAckSeen = if_ack;
            dAckSeen  = d_ack;
            if (idle) begin
                ifEff   = if_req && !expAckIf;
                dEff    = d_req && !expAckD;
                grantD  = dEff && !(ifEff && starve == STARVE_MAX);
                grantIf = ifEff && !grantD;
                if (!if_req || grantIf) starve = 0;
                else if (grantD && starve < STARVE_MAX) starve++;
                if (grantD || grantIf) begin
                    mOwnD  = grantD;
                    mWe    = grantD && d_we;
                    mAddr  = grantD ? d_addr : if_addr;
                    mWdata = grantD ? d_wdata : 16'h0;
                    mData  = memArr[mAddr];
                    mIssue = k + 1;
                    mAck   = k + 2 + MEM_LAT;
                end
            end
        end
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) memArr[a] = 16'($urandom);
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write();
        test_reset_wait();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the instruction-fetch stage and the memory stage of the 16-bit pipelined CPU. It accepts held-high requests from both stages, issues one access at a time, and returns read data with a one-cycle ack pulse. It drives stall signals back to the pipeline while a stage's request is outstanding. Data accesses have priority, with a bounded starvation guard for fetch.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, cycles from issue cycle to valid mem_rdata; legal range 1..8, elaboration error otherwise
STARVE_MAX, 3, max consecutive data grants while fetch waits before fetch is forced to win

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched word, registered, held until next fetch ack
if_ack  out  1  one-cycle pulse, fetch complete
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered, held until next data read ack
d_ack  out  1  one-cycle pulse, data access complete
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
stall_if  out  1  if_req & ~if_ack, combinational
stall_mem  out  1  d_req & ~d_ack, combinational
busy  out  1  FSM not in IDLE

Behaviour:
- Clock is clk. Reset is asynchronous and active-high (reset). All registered outputs clear to 0 while reset is high. State goes to IDLE, and the starvation and latency counters clear. An in-flight access is abandoned: mem_en drops immediately and no ack is produced for it.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: if any unmasked request is present, pick a winner and latch owner, addr, we, and wdata; go to ISSUE. Otherwise stay in IDLE.
- Masking: a port's req is ignored in the cycle its own ack is high, because the requester has not yet advanced its address.
- Arbitration: d_req wins over if_req. Exception: if starve_cnt == STARVE_MAX and if_req is high, fetch wins.
- starve_cnt: increments on each data grant made while if_req is high. It clears on a fetch grant, and in any IDLE cycle where if_req is low. It saturates at STARVE_MAX.
- ISSUE: mem_en=1 for exactly one cycle, with mem_we = latched we and mem_addr/mem_wdata from the latched values. Load lat_cnt = MEM_LAT-1. Go to WAIT, or straight to CAPTURE when MEM_LAT == 1.
- WAIT: decrement lat_cnt. At 0, go to CAPTURE.
- CAPTURE: this is the cycle in which mem_rdata is valid. At the clock edge:
  - a fetch owner loads if_rdata from mem_rdata;
  - a data read loads d_rdata;
  - a data write leaves d_rdata unchanged.
  The owner's ack is registered high for the next cycle, and the FSM returns to IDLE.
- Timing: request first seen in IDLE at cycle t gives mem_en at t+1 and ack at t+2+MEM_LAT. The ack cycle is IDLE, so a new request is arbitrated there and issued at t+3+MEM_LAT.
- mem_en, mem_we, mem_addr, and mem_wdata are 0 outside ISSUE.
- Dropping a req mid-access is a protocol violation. The access still completes and the ack still pulses.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum {IDLE, ISSUE, WAIT, CAPTURE};
  - owner constants OWN_IF=0, OWN_D=1;
  - default ADDR_W/DATA_W.
- One sub-module, mem_lat_timer: loadable down-counter of width clog2(MEM_LAT)+1 with a done flag. The arbiter FSM, arbitration logic, and output registers live in mem_port_arbiter.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0010 at cycle 0; memory returns 0xABCD in cycle 3 -> mem_en=1/mem_addr=0x0010 in cycle 1; if_ack=1 and if_rdata=0xABCD in cycle 4; stall_if=1 in cycles 0-3.
- Simultaneous requests at cycle 0, if_addr=0x0020 and d_addr=0x0100 read -> data issued in cycle 1, d_ack in cycle 4; fetch issued in cycle 5, if_ack in cycle 8.
- Starvation, STARVE_MAX=3, d_req held continuously with new addresses, if_req held -> grant order D, D, D, IF, D; starve_cnt returns to 0 after the IF grant.
- Write, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> one ISSUE cycle with mem_we=1 and mem_wdata=0x1234; d_ack after MEM_LAT+2 cycles; d_rdata keeps its prior value.
- Reset during WAIT: reset asserted mid-access -> mem_en and all outputs 0 immediately; no ack after reset release; the next if_req is serviced with normal latency.
- Ack masking and back-to-back fetch: if_req held through if_ack -> no duplicate issue in the ack cycle; a new if_addr presented after the ack is issued the following cycle.
